// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - Leading-zero-blanking buffer builder and multiplexed digit scanner
module display_scan_ctrl #(
  parameter int DIGIT_NUM        = 8,
  parameter int SCAN_DIV         = 50000,
  parameter logic [3:0] BLANK_CODE = 4'hF,
  localparam int IW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1,
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIGIT_NUM*4-1:0] num_in,
  input  logic                   load,
  input  logic                   blank_en,
  output logic                   busy,
  output logic [3:0]             digit_code,
  output logic [DIGIT_NUM-1:0]   digit_sel,
  output logic [IW-1:0]          digit_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [IW-1:0] MSD_IDX  = IW'(DIGIT_NUM - 1);
  localparam logic [PW-1:0] TC_COUNT = PW'(SCAN_DIV - 1);

  state_t                 state;
  logic [DIGIT_NUM*4-1:0] shadow;
  logic                   shadow_blank;
  logic [IW-1:0]          walk_ptr;
  logic                   seen_nonzero;
  logic                   scanning;
  logic [3:0]             stage_buf   [DIGIT_NUM];
  logic [3:0]             display_buf [DIGIT_NUM];
  logic [PW-1:0]          prescale;

  // Nibble under the walk pointer and its blanking decision
  logic [3:0] walk_nib;
  logic       walk_blank;
  always_comb begin
    walk_nib   = shadow[{walk_ptr, 2'b00} +: 4];
    walk_blank = shadow_blank && !seen_nonzero && (walk_nib == 4'h0);
  end

  // Scan position for the coming cycle; counters only move once a digit is on
  logic          scan_live;
  logic          term_count;
  logic [PW-1:0] prescale_nx;
  logic [IW-1:0] idx_nx;
  always_comb begin
    scan_live   = (digit_sel != '0);
    term_count  = (prescale == TC_COUNT);
    prescale_nx = prescale;
    idx_nx      = digit_idx;
    if (scan_live) begin
      if (term_count) begin
        prescale_nx = '0;
        idx_nx      = (digit_idx == MSD_IDX) ? '0 : digit_idx + IW'(1);
      end else begin
        prescale_nx = prescale + PW'(1);
      end
    end
  end

  // Capture, MSD-to-LSD blanking walk, and atomic swap into the display buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      shadow       <= '0;
      shadow_blank <= 1'b0;
      walk_ptr     <= MSD_IDX;
      seen_nonzero <= 1'b0;
      scanning     <= 1'b0;
      for (int i = 0; i < DIGIT_NUM; i++) begin
        stage_buf[i]   <= BLANK_CODE;
        display_buf[i] <= BLANK_CODE;
      end
    end else if (load) begin
      // A load in any state restarts the capture; any partial staging is abandoned
      state        <= PREP;
      busy         <= 1'b1;
      shadow       <= num_in;
      shadow_blank <= blank_en;
      walk_ptr     <= MSD_IDX;
      seen_nonzero <= 1'b0;
    end else if (state == PREP) begin
      if (walk_ptr != '0) begin
        stage_buf[walk_ptr] <= walk_blank ? BLANK_CODE : walk_nib;
        seen_nonzero        <= seen_nonzero || (walk_nib != 4'h0);
        walk_ptr            <= walk_ptr - IW'(1);
      end else begin
        // Digit 0 is never blanked, so it goes straight from the shadow
        display_buf[0] <= shadow[3:0];
        for (int i = 1; i < DIGIT_NUM; i++) begin
          display_buf[i] <= stage_buf[i];
        end
        state    <= SCAN;
        busy     <= 1'b0;
        scanning <= 1'b1;
      end
    end
  end

  // Prescaler, digit index and registered digit drive, untouched by loads
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale   <= '0;
      digit_idx  <= '0;
      digit_sel  <= '0;
      digit_code <= BLANK_CODE;
    end else begin
      prescale  <= prescale_nx;
      digit_idx <= idx_nx;
      if (scanning) begin
        digit_sel  <= DIGIT_NUM'(1) << idx_nx;
        digit_code <= display_buf[idx_nx];
      end else begin
        digit_sel  <= '0;
        digit_code <= BLANK_CODE;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - Scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;

  localparam int DIGIT_NUM = 4;
  localparam int SCAN_DIV  = 4;

  logic        clk;
  logic        reset;
  logic [15:0] num_in;
  logic        load;
  logic        blank_en;
  logic        busy;
  logic [3:0]  digit_code;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;

  display_scan_ctrl #(
    .DIGIT_NUM (DIGIT_NUM),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .num_in    (num_in),
    .load      (load),
    .blank_en  (blank_en),
    .busy      (busy),
    .digit_code(digit_code),
    .digit_sel (digit_sel),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] code;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Monitor: every new digit or code presented pops one expectation
  logic [3:0] prev_sel  = 4'b0000;
  logic [3:0] prev_code = 4'hF;
  int         hold      = 0;
  always @(negedge clk) begin
    exp_t e;
    if (digit_sel != prev_sel || (digit_sel != 4'b0000 && digit_code != prev_code)) begin
      if (digit_sel != 4'b0000 && prev_sel != 4'b0000 && digit_sel != prev_sel) begin
        checks++;
        if (hold != SCAN_DIV) begin
          fails++;
          $display("FAIL hold_len: sel %b held %0d cycles, required %0d", prev_sel, hold, SCAN_DIV);
        end
      end
      if (digit_sel != 4'b0000 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (digit_sel !== e.sel || digit_code !== e.code || digit_idx !== e.idx) begin
          fails++;
          $display("FAIL scan_event: got sel=%b code=%h idx=%0d, required sel=%b code=%h idx=%0d",
                   digit_sel, digit_code, digit_idx, e.sel, e.code, e.idx);
        end
      end
    end
    hold      = (digit_sel != prev_sel) ? 1 : hold + 1;
    prev_sel  = digit_sel;
    prev_code = digit_code;
  end

  task automatic push(input logic [3:0] sel, input logic [3:0] code, input logic [1:0] idx);
    exp_t e;
    e.sel  = sel;
    e.code = code;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3);
    push(4'b0001, c0, 2'd0);
    push(4'b0010, c1, 2'd1);
    push(4'b0100, c2, 2'd2);
    push(4'b1000, c3, 2'd3);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge just after the edge that samples load
  task automatic do_load(input logic [15:0] v, input logic b);
    num_in   = v;
    blank_en = b;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic busy_window(input string name, input int hi);
    for (int i = 0; i < hi; i++) begin
      check(name, {7'd0, busy}, 8'h01);
      @(negedge clk);
    end
    check(name, {7'd0, busy}, 8'h00);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    num_in   = 16'h0000;
    blank_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_state", {digit_sel, digit_code}, 8'h0F);
      check("idle_busy", {6'd0, busy, digit_idx == 2'd0}, 8'h01);
    end

    // 0305 blanked: busy window, first digit latency, frame 5,0,3,F
    push_frame(4'h5, 4'h0, 4'h3, 4'hF);
    do_load(16'h0305, 1'b1);
    busy_window("busy_0305", 4);
    check("sel_before_scan", {4'd0, digit_sel}, 8'h00);
    @(negedge clk);
    check("sel_first_digit", {digit_sel, digit_code}, 8'h15);
    wait_drain();

    // All-zero, blanked and raw
    do_reset();
    push_frame(4'h0, 4'hF, 4'hF, 4'hF);
    do_load(16'h0000, 1'b1);
    wait_drain();
    do_reset();
    push_frame(4'h0, 4'h0, 4'h0, 4'h0);
    do_load(16'h0000, 1'b0);
    wait_drain();

    // Raw mode keeps hex nibbles and zeros
    do_reset();
    push_frame(4'hA, 4'h0, 4'h0, 4'hF);
    do_load(16'hF00A, 1'b0);
    wait_drain();

    // Load mid-digit while scanning 1234: old codes persist, cadence unbroken
    do_reset();
    push(4'b0001, 4'h4, 2'd0);
    push(4'b0010, 4'h3, 2'd1);
    push(4'b0100, 4'h2, 2'd2);
    push(4'b0100, 4'hF, 2'd2);
    push(4'b1000, 4'hF, 2'd3);
    push(4'b0001, 4'h2, 2'd0);
    push(4'b0010, 4'h4, 2'd1);
    push(4'b0100, 4'hF, 2'd2);
    do_load(16'h1234, 1'b1);
    repeat (9) @(negedge clk);
    do_load(16'h0042, 1'b1);
    busy_window("busy_reload", 4);
    wait_drain();

    // Reload during PREP: latest value wins, 1111 never shown
    do_reset();
    push_frame(4'h0, 4'h0, 4'h9, 4'hF);
    do_load(16'h1111, 1'b1);
    check("busy_first", {7'd0, busy}, 8'h01);
    @(negedge clk);
    do_load(16'h0900, 1'b1);
    busy_window("busy_restart", 4);
    wait_drain();

    // Reset during PREP while scanning
    do_reset();
    do_load(16'h1234, 1'b1);
    repeat (8) @(negedge clk);
    check("scan_running", {7'd0, digit_sel != 4'b0000}, 8'h01);
    do_load(16'h5678, 1'b1);
    @(negedge clk);
    do_reset();
    check("reset_outputs", {digit_sel, digit_code}, 8'h0F);
    check("reset_busy_idx", {6'd0, busy, digit_idx}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_idle", {digit_sel, digit_code}, 8'h0F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the multiplexed seven-segment display path. It captures a packed BCD number on a load strobe and builds a leading-zero-blanked display buffer sequentially, one digit per clock. It then time-multiplexes the buffer onto the shared segment decoder, driving one digit select at a time. It sits between the arithmetic/result logic and the BCD-to-segment decoder plus digit drivers.

## Interface

Parameters:
- DIGIT_NUM, 8, number of digits; nibble i of num_in is digit i, with digit 0 the LSD at bits [3:0].
- SCAN_DIV, 50000, clocks each digit stays selected (≥2).
- BLANK_CODE, 4'hF, nibble the segment decoder renders as all-off.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- num_in  in  DIGIT_NUM*4  packed BCD value; sampled only on load.
- load  in  1  single-cycle strobe; captures num_in and blank_en.
- blank_en  in  1  1 = blank leading zeros; 0 = show all digits raw.
- busy  out  1  high while the buffer is being rebuilt (PREP).
- digit_code  out  4  nibble for the currently selected digit.
- digit_sel  out  DIGIT_NUM  one-hot active-high digit enable; all-zero when idle.
- digit_idx  out  $clog2(DIGIT_NUM)  index of the selected digit.

## Operation

- FSM states: IDLE, PREP, SCAN.
- IDLE (after reset):
  - digit_sel = 0, digit_code = BLANK_CODE.
  - The prescaler and digit counter are held at 0.
  - load moves to PREP.
- PREP:
  - On load, num_in goes to a shadow register and blank_en to a shadow flag, with a walk pointer at MSD (DIGIT_NUM-1).
  - Each clock processes one digit, from MSD down to LSD, and writes a staging buffer.
  - A digit is replaced by BLANK_CODE iff shadow blank_en = 1, its nibble == 0, no nonzero nibble was seen above it, and it is not digit 0.
  - Otherwise the nibble is copied unchanged, including values 0xA–0xF. Any nonzero nibble ends blanking.
  - Digit 0 is never blanked, so an all-zero value displays "0".
  - After the LSD is processed, the staging buffer is copied to the display buffer in one cycle. Next state is SCAN.
- SCAN:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count, digit_idx advances (wrap DIGIT_NUM-1 → 0) and the prescaler returns to 0.
  - digit_sel = 1 << digit_idx; digit_code = display_buffer[digit_idx].
- Loading while scanning:
  - load in SCAN enters PREP, but scanning continues from the old display buffer throughout PREP.
  - The prescaler and digit_idx are never reset by a load, so there is no flicker or glitch.
- Loading during PREP:
  - load in PREP restarts the capture: new shadow value, pointer back to MSD. The latest value wins.
  - The partially built staging buffer is discarded.
- Buffer swap: the display buffer changes only in the swap cycle, atomically for all digits.
- Reset mid-operation returns to IDLE with all outputs at reset values. Any pending PREP is lost.

## Timing

- Reset values:
  - busy = 0, digit_sel = 0, digit_code = BLANK_CODE, digit_idx = 0.
  - Prescaler = 0; display buffer all BLANK_CODE.
- Outputs are registered.
- For load sampled high at edge t:
  - busy is high from cycle t+1 through t+DIGIT_NUM.
  - The new buffer drives digit_code starting at cycle t+DIGIT_NUM+1.
- First load from IDLE:
  - SCAN begins at t+DIGIT_NUM+1 with digit_idx = 0 and the prescaler at 0.
  - digit_sel stays 0 until then.
- Each digit is held exactly SCAN_DIV clocks; a full frame is DIGIT_NUM*SCAN_DIV clocks.
- digit_idx, digit_sel and digit_code change on the same edge. There is never more than one bit set in digit_sel.
- Load and terminal count in the same cycle: both take effect. Scan advances on schedule, and PREP starts.

## Test plan

Bench parameters: DIGIT_NUM=4, SCAN_DIV=4.

- Reset, then 20 idle cycles → digit_sel=0000, digit_code=F, busy=0 throughout.
- load num_in=16'h0305 with blank_en=1 at t → busy high t+1..t+4. From t+5, digit_sel is 0001,0010,0100,1000, each held 4 clocks, with digit_code 5,0,3,F.
- load 16'h0000 with blank_en=1 → codes 0,F,F,F. With blank_en=0 → codes 0,0,0,0.
- While scanning 16'h1234, load 16'h0042 mid-digit → digit_idx cadence unbroken. The old codes persist for 4 cycles after load; then codes 2,4,F,F.
- load 16'h1111, then load 16'h0900 two cycles later → busy stays high until 4 cycles after the second load. Final codes are 0,0,9,F; 1111 is never shown.
- Assert reset during PREP → next cycle digit_sel=0000, busy=0, digit_code=F. No scanning until the next load.
